// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: load FSM states and
// the default geometry (word width, memory depth) the loader is built for.
package imem_boot_loader_pkg;

    localparam int IMW_CFG   = 4;
    localparam int IW_CFG    = 32;
    localparam int BPW       = IW_CFG / 8;
    localparam int MAX_WORDS = 2 ** IMW_CFG;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        CHECK,
        RUN,
        ERROR
    } state_t;

    function automatic int bpw_of(input int iw);
        return iw / 8;
    endfunction

    function automatic int max_words_of(input int imw);
        return 2 ** imw;
    endfunction

endpackage

// File: rtl/imem_boot_loader_byte_word_packer.sv
// Assembles little-endian bytes into IW-bit words; 'word' is the word as it will
// look once the byte currently presented is written, so it is complete on word_done.
module imem_boot_loader_byte_word_packer #(
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [7:0]    byte_data,
    output logic          last_lane,
    output logic          word_done,
    output logic [IW-1:0] word
);
    localparam int LANES = IW / 8;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0] lane_q;
    logic [IW-1:0] shift_q;

    assign last_lane = (int'(lane_q) == LANES - 1);
    assign word_done = en && last_lane;

    always_comb begin
        word = shift_q;
        word[int'(lane_q) * 8 +: 8] = byte_data;
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else if (en) begin
            shift_q[int'(lane_q) * 8 +: 8] <= byte_data;
            lane_q <= last_lane ? '0 : lane_q + LW'(1);
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a count byte, N words of little-endian data and an XOR checksum
// over a byte handshake, writes the words to instruction memory, then releases the core.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int IMW = IMW_CFG,
    parameter int IW  = IW_CFG
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           byte_valid,
    input  logic [7:0]     byte_data,
    output logic           byte_ready,
    output logic           im_we,
    output logic [IMW-1:0] im_waddr,
    output logic [IW-1:0]  im_wdata,
    output logic           start,
    output logic           busy,
    output logic           error
);
    localparam int WORDS = max_words_of(IMW);

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
    // byte_ready depends only on the state, never on byte_valid.
    state_t         state_q, state_d;
    logic [IMW:0]   n_words_q;
    logic [IMW-1:0] word_idx_q;
    logic [7:0]     cks_q;
    logic           count_ok, last_word;
    logic           packer_en, packer_clr, last_lane, word_done;
    logic [IW-1:0]  word;

    assign count_ok  = (int'(byte_data) >= 1) && (int'(byte_data) <= WORDS);
    assign last_word = ({1'b0, word_idx_q} == n_words_q - (IMW + 1)'(1));

    imem_boot_loader_byte_word_packer #(.IW(IW)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (packer_clr),
        .en        (packer_en),
        .byte_data (byte_data),
        .last_lane (last_lane),
        .word_done (word_done),
        .word      (word)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        byte_ready = 1'b0;
        busy       = 1'b0;
        start      = 1'b0;
        error      = 1'b0;
        packer_en  = 1'b0;
        packer_clr = 1'b0;
        case (state_q)
            IDLE: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    packer_clr = 1'b1;
                    state_d    = count_ok ? DATA : ERROR;
                end
            end
            DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    packer_en = 1'b1;
                    if (last_lane && last_word) state_d = CHECK;
                end
            end
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) state_d = (byte_data == cks_q) ? RUN : ERROR;
            end
            RUN:     start = 1'b1;
            ERROR:   error = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // The memory write is registered, so it lands one cycle after the last byte of a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_words_q  <= '0;
            word_idx_q <= '0;
            cks_q      <= '0;
            im_we      <= 1'b0;
            im_waddr   <= '0;
            im_wdata   <= '0;
        end else begin
            im_we <= 1'b0;
            if (state_q == IDLE && byte_valid) begin
                n_words_q  <= (IMW + 1)'(byte_data);
                word_idx_q <= '0;
                cks_q      <= '0;
            end
            if (packer_en) begin
                cks_q <= cks_q ^ byte_data;
                if (word_done) begin
                    im_we    <= 1'b1;
                    im_waddr <= word_idx_q;
                    im_wdata <= word;
                    if (!last_word) word_idx_q <= word_idx_q + IMW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: count-byte table, hand-written corner sequences and
// randomized image loads checked against an image-level reference model.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int TB_IMW = IMW_CFG;
    localparam int TB_IW  = IW_CFG;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready, im_we, start, busy, error;
    logic [TB_IMW-1:0] im_waddr;
    logic [TB_IW-1:0]  im_wdata;

    imem_boot_loader #(.IMW(TB_IMW), .IW(TB_IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_waddr   (im_waddr),
        .im_wdata   (im_wdata),
        .start      (start),
        .busy       (busy),
        .error      (error)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TB_IMW+TB_IW-1:0] exp_q[$];
    logic [TB_IW-1:0]        img[$];

    typedef struct {
        logic [7:0] count;
        bit         exp_err;
    } cnt_vec_t;
    cnt_vec_t cvec[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TB_IMW+TB_IW-1:0] mk_exp(input int addr, input logic [TB_IW-1:0] d);
        return {TB_IMW'(addr), d};
    endfunction

    // Called at a falling edge; leaves the bench at a falling edge with rst low.
    task automatic do_reset();
        rst = 1'b1;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1);
        check({tag, "_im_we"}, im_we, 0);
        check({tag, "_im_waddr"}, im_waddr, 0);
        check({tag, "_im_wdata"}, im_wdata, 0);
        check({tag, "_start"}, start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // ---------------- driver ----------------
    task automatic send_byte(input logic [7:0] b, input int bubble_pct);
        while ($urandom_range(99) < bubble_pct) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Reference model: words come straight from img, checksum is the XOR of every
    // data byte, and the load must end in RUN exactly when the checksum byte matches.
    task automatic run_load(input int n, input bit bad, input int bubble_pct, input string tag);
        logic [7:0]       cks;
        logic [TB_IW-1:0] w;
        logic [7:0]       b;
        cks = 8'h00;
        send_byte(8'(n), bubble_pct);
        check({tag, "_busy_after_count"}, busy, 1);
        for (int k = 0; k < n; k++) begin
            w = img[k];
            for (int j = 0; j < TB_IW / 8; j++) begin
                b = w[8*j +: 8];
                cks = cks ^ b;
                if (j == TB_IW / 8 - 1) exp_q.push_back(mk_exp(k, w));
                send_byte(b, bubble_pct);
            end
        end
        check({tag, "_start_before_cks"}, start, 0);
        send_byte(bad ? cks + 8'h01 : cks, bubble_pct);
        check({tag, "_start"}, start, bad ? 0 : 1);
        check({tag, "_error"}, error, bad ? 1 : 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_ready_done"}, byte_ready, 0);
        check({tag, "_writes_left"}, exp_q.size(), 0);
    endtask

    // ---------------- scoreboard: every memory write ----------------
    always @(negedge clk) begin
        if (!rst && im_we) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write", im_waddr, im_wdata);
            end else begin
                logic [TB_IMW+TB_IW-1:0] e;
                e = exp_q.pop_front();
                if ({im_waddr, im_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                             im_waddr, im_wdata, e[TB_IMW+TB_IW-1:TB_IW], e[TB_IW-1:0]);
                end
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        cvec[0] = '{8'h00, 1'b1};
        cvec[1] = '{8'h11, 1'b1};
        cvec[2] = '{8'hFF, 1'b1};
        cvec[3] = '{8'h01, 1'b0};
        cvec[4] = '{8'h10, 1'b0};
        cvec[5] = '{8'h09, 1'b0};

        @(negedge clk);
        do_reset();
        check_reset_outputs("reset");

        // Count byte table: out-of-range counts fail at once and never write.
        foreach (cvec[i]) begin
            do_reset();
            send_byte(cvec[i].count, 0);
            check($sformatf("count_%0h_error", cvec[i].count), error, cvec[i].exp_err);
            check($sformatf("count_%0h_busy", cvec[i].count), busy, !cvec[i].exp_err);
            check($sformatf("count_%0h_ready", cvec[i].count), byte_ready, !cvec[i].exp_err);
            check($sformatf("count_%0h_start", cvec[i].count), start, 0);
        end

        // Single-word image with explicit latency checks.
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h13, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check("n1_no_early_we", im_we, 0);
        exp_q.push_back(mk_exp(0, 32'h0000_0013));
        send_byte(8'h00, 0);
        check("n1_we_latency", im_we, 1);
        check("n1_waddr", im_waddr, 0);
        check("n1_wdata", im_wdata, 32'h0000_0013);
        check("n1_start_before", start, 0);
        send_byte(8'h13, 0);
        check("n1_start", start, 1);
        check("n1_error", error, 0);
        @(negedge clk);
        check("n1_we_single", im_we, 0);
        check("n1_start_held", start, 1);

        // Full memory.
        do_reset();
        img.delete();
        for (int k = 0; k < 16; k++) img.push_back(32'h0010_0093 + k);
        run_load(16, 1'b0, 0, "n16");

        // RUN ignores traffic; rst drops start on the next edge.
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("run_ready", byte_ready, 0);
            check("run_we", im_we, 0);
            check("run_start", start, 1);
        end
        byte_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("run_rst_start", start, 0);
        rst = 1'b0;

        // Bad checksum: writes happen, then sticky error.
        do_reset();
        img.delete();
        for (int k = 0; k < 2; k++) img.push_back($urandom);
        run_load(2, 1'b1, 0, "badcks");
        for (int c = 0; c < 3; c++) begin
            send_byte(8'(c + 1), 0);
            check("badcks_sticky_error", error, 1);
            check("badcks_sticky_ready", byte_ready, 0);
            check("badcks_sticky_start", start, 0);
        end

        // Reset mid-load after six data bytes, then a clean reload.
        do_reset();
        img.delete();
        for (int k = 0; k < 2; k++) img.push_back($urandom);
        send_byte(8'h02, 40);
        for (int j = 0; j < 6; j++) begin
            logic [TB_IW-1:0] w;
            w = img[j / 4];
            if (j == 3) exp_q.push_back(mk_exp(0, w));
            send_byte(w[8*(j%4) +: 8], 40);
        end
        check("midrst_busy", busy, 1);
        do_reset();
        check_reset_outputs("midrst");
        img.delete();
        for (int k = 0; k < 2; k++) img.push_back($urandom);
        run_load(2, 1'b0, 40, "reload");

        // Randomized images against the model.
        for (int t = 0; t < 10; t++) begin
            int n;
            bit bad;
            n   = $urandom_range(1, MAX_WORDS);
            bad = ($urandom_range(0, 3) == 0);
            do_reset();
            img.delete();
            for (int k = 0; k < n; k++) img.push_back($urandom);
            run_load(n, bad, 30, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the processor core.
- Receives a program image as a byte stream over a valid/ready handshake.
- Packs the bytes into IW-bit instructions and writes them into instruction memory.
- Verifies a checksum, then raises `start` to release the core.
- The core's `start` input is driven only by this block.

Parameters:
- IMW, 4, instruction-memory address width; capacity is 2**IMW words.
- IW, 32, instruction width in bits; must be a multiple of 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte.
- byte_ready  out  1  block accepts a byte this cycle.
- im_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- im_waddr  out  IMW  instruction-memory write address.
- im_wdata  out  IW  instruction-memory write data.
- start  out  1  core release; held high after a successful load.
- busy  out  1  a load is in progress (states DATA or CHECK).
- error  out  1  load failed; sticky until rst.

Behaviour:
- Handshake:
  - A byte is accepted on a rising edge where byte_valid && byte_ready.
  - byte_data is ignored otherwise.
  - Bubbles (byte_valid low) are allowed anywhere and stall the FSM.
- Reset values, applied synchronously on rst:
  - State IDLE; byte_ready=1; im_we=0; im_waddr=0; im_wdata=0; start=0; busy=0; error=0.
  - Internal word count, byte index, word index and checksum are all cleared.
  - rst dominates any simultaneous handshake.
- Image format, in order:
  - One count byte N, giving the number of words.
  - N*BPW data bytes, where BPW=IW/8, little-endian (first byte goes to bits [7:0]).
  - One checksum byte equal to the XOR of all data bytes.
  - The count byte is not included in the checksum.
- State IDLE (byte_ready=1):
  - Accept the count byte.
  - If 1 <= N <= 2**IMW: store N, clear the checksum, go to DATA.
  - Otherwise (N=0 or N>2**IMW): go to ERROR.
- State DATA (byte_ready=1, busy=1):
  - Each accepted byte is shifted into the word register at its lane and XORed into the checksum.
  - When byte BPW-1 of a word is accepted, on the next cycle:
    - im_we=1 for exactly one cycle;
    - im_waddr = word index (0-based), im_wdata = the completed word;
    - the word index increments.
  - After word N-1 completes, go to CHECK.
  - No wrap: the word index never exceeds N-1 <= 2**IMW-1.
- State CHECK (byte_ready=1, busy=1):
  - Accept one byte.
  - If it equals the running checksum: go to RUN.
  - Otherwise go to ERROR.
  - The final im_we pulse may coincide with the first CHECK cycle. This is legal: the write is issued from a register.
- State RUN:
  - byte_ready=0; start=1 from the cycle after the checksum byte is accepted, held until rst.
  - busy=0; im_we=0.
- State ERROR:
  - byte_ready=0, error=1, start=0, im_we=0.
  - Held until rst.
- im_waddr and im_wdata hold their last values when im_we=0.
- Reset mid-load:
  - The FSM returns to IDLE and start stays 0.
  - Words already written remain in memory; memory is not cleared.
  - A fresh image reloads cleanly from address 0.
- Latency:
  - Last byte of a word accepted → im_we one cycle later.
  - Checksum byte accepted → start high one cycle later.

Decomposition:
- Shared package holds:
  - state encoding: IDLE, DATA, CHECK, RUN, ERROR;
  - localparam BPW = IW/8;
  - localparam MAX_WORDS = 2**IMW.
- One natural sub-module: byte_word_packer.
  - Byte-lane shift register plus lane counter.
  - Outputs the completed word and a word_done pulse.
- The top level holds the FSM, word counter, checksum and outputs.

Test Plan:
- N=1, bytes 0x01,0x13,0x00,0x00,0x00, checksum 0x13 → single im_we pulse with addr 0, data 0x00000013; start=1 one cycle after checksum acceptance; error=0.
- N=16, words k = 0x00100093+k, correct checksum → 16 pulses at addr 0..15 in order, with matching data; start=1; no write at any address above 15.
- N=2, valid data, checksum byte off by 0x01 → two writes occur; then error=1, start=0, byte_ready=0, and later bytes are ignored.
- Count byte 0x00, then (after rst) count byte 0x11 → error=1 on the cycle after the count byte, with no im_we either time.
- N=2 with random byte_valid bubbles, and rst asserted after 6 data bytes → after rst, all outputs are at reset values; a full reload then writes addr 0 and 1 correctly and start rises.
- In RUN, drive byte_valid=1 with 0xFF for 10 cycles → byte_ready=0, no im_we, start stays 1; rst then drops start to 0 on the next edge.
